// File: rtl/interpo_multi_pkg.sv
// Shared helpers for the multi-channel linear interpolator: width arithmetic,
// default configuration and the output clamp.
// Optional feature macro: INTERPO_MULTI_ROUND_EN (round-half-up instead of floor).
package interpo_pkg;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_CHANNELS = 3;
   localparam int DEF_RATIO    = 6;

   // Ceiling log2; a weight counter holding 0..RATIO-1 needs clog2(RATIO) bits.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   // Width of the shared weight counter W.
   function automatic int w_width(input int ratio);
      return clog2(ratio);
   endfunction

   // Width of the signed difference D2-D1.
   function automatic int diff_width(input int width);
      return width + 1;
   endfunction

   // Width of the signed product DIFF*W (the extra bit is W's sign slot).
   function automatic int prod_width(input int width, input int ratio);
      return diff_width(width) + w_width(ratio) + 1;
   endfunction

   // Saturate a signed value into the unsigned range 0..hi.
   function automatic int sat_clamp(input int value, input int hi);
      if (value < 0) return 0;
      if (value > hi) return hi;
      return value;
   endfunction

endpackage

// File: rtl/interpo_multi_if.sv
// Sample-stream bundle between the pixel pipeline and the interpolator:
// strobe, mode, packed input samples and the packed interpolated output.
interface interpo_multi_if #(
   parameter int WIDTH    = interpo_pkg::DEF_WIDTH,
   parameter int CHANNELS = interpo_pkg::DEF_CHANNELS
);

   logic                      CLKENA;
   logic                      ENABLE;
   logic [CHANNELS*WIDTH-1:0] IDATA;
   logic [CHANNELS*WIDTH-1:0] ODATA;
   logic                      OVALID;

   modport master (
      output CLKENA,
      output ENABLE,
      output IDATA,
      input  ODATA,
      input  OVALID
   );

   modport slave (
      input  CLKENA,
      input  ENABLE,
      input  IDATA,
      output ODATA,
      output OVALID
   );

endinterface

// File: rtl/interpo_multi_chan.sv
// One channel of the interpolator: two-sample delay line, stage-1 product
// register, stage-2 divide/add/clamp register.
// Optional feature macro: INTERPO_MULTI_ROUND_EN (round-half-up division).
module interpo_chan
   import interpo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int RATIO = DEF_RATIO
) (
   input  logic                       CLK21M,
   input  logic                       RESET_N,
   input  logic                       clkena,
   input  logic [w_width(RATIO)-1:0]  weff,
   input  logic [WIDTH-1:0]           idata,
   output logic [WIDTH-1:0]           odata
);

   localparam int DIFF_W  = diff_width(WIDTH);
   localparam int PROD_W  = prod_width(WIDTH, RATIO);
   localparam int QW      = PROD_W + 2;
   localparam int MAX_VAL = (1 << WIDTH) - 1;

`ifdef INTERPO_MULTI_ROUND_EN
   localparam logic signed [QW-1:0] DEN = QW'(2 * RATIO);
`else
   localparam logic signed [QW-1:0] DEN = QW'(RATIO);
`endif

   logic [WIDTH-1:0]         d1;
   logic [WIDTH-1:0]         d2;
   logic [WIDTH-1:0]         s1_d1;
   logic signed [DIFF_W-1:0] diff;
   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] s1_prod;
   logic signed [QW-1:0]     num;
   logic signed [QW-1:0]     quo;
   logic signed [QW-1:0]     rem;
   logic signed [QW-1:0]     sum;
   logic [WIDTH-1:0]         odata_next;

   // Delay line: each strobe shifts the newest sample into D2 and the older into D1.
   always_ff @(posedge CLK21M or negedge RESET_N) begin
      if (!RESET_N) begin
         d1 <= '0;
         d2 <= '0;
      end else if (clkena) begin
         d2 <= idata;
         d1 <= d2;
      end
   end

   // Signed slope times the effective weight; weff is already zero in bypass.
   always_comb begin
      diff = $signed({1'b0, d2}) - $signed({1'b0, d1});
      prod = PROD_W'(diff) * PROD_W'($signed({1'b0, weff}));
   end

   // Stage 1 captures the product together with the matching D1.
   always_ff @(posedge CLK21M or negedge RESET_N) begin
      if (!RESET_N) begin
         s1_prod <= '0;
         s1_d1   <= '0;
      end else begin
         s1_prod <= prod;
         s1_d1   <= d1;
      end
   end

   // Exact division toward minus infinity (truncating divide, then fix up negative remainders), add D1, clamp.
   always_comb begin
      num = '0;
      quo = '0;
      rem = '0;
      sum = '0;
`ifdef INTERPO_MULTI_ROUND_EN
      num = (QW'(s1_prod) <<< 1) + QW'(RATIO);
`else
      num = QW'(s1_prod);
`endif
      quo = num / DEN;
      rem = num % DEN;
      if ((num < 0) && (rem != '0)) quo = quo - QW'(1);
      sum = QW'($signed({1'b0, s1_d1})) + quo;
      odata_next = WIDTH'(sat_clamp(int'(sum), MAX_VAL));
   end

   // Stage 2 registers the clamped interpolated sample.
   always_ff @(posedge CLK21M or negedge RESET_N) begin
      if (!RESET_N) begin
         odata <= '0;
      end else begin
         odata <= odata_next;
      end
   end

endmodule

// File: rtl/interpo_multi.sv
// Multi-channel linear interpolator upsampling a strobed sample stream to
// the CLK21M rate, with bypass (sample-and-hold) and an output-valid flag.
// Optional feature macro: INTERPO_MULTI_ROUND_EN (round-half-up division).
module interpo_multi
   import interpo_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int RATIO    = DEF_RATIO
) (
   input  logic            CLK21M,
   input  logic            RESET_N,
   interpo_multi_if.slave  pix
);

   localparam int              W_W   = w_width(RATIO);
   localparam logic [W_W-1:0]  W_MAX = W_W'(RATIO - 1);

   logic [W_W-1:0]            w;
   logic [W_W-1:0]            weff;
   logic [1:0]                fill;
   logic                      valid_s1;
   logic                      ovalid_q;
   logic [WIDTH-1:0]          chan_out [CHANNELS];
   logic [CHANNELS*WIDTH-1:0] odata_bus;

   // Weight counter: cleared by each strobe, then climbs and parks at RATIO-1 so a late strobe holds the last step.
   always_ff @(posedge CLK21M or negedge RESET_N) begin
      if (!RESET_N) begin
         w <= '0;
      end else if (pix.CLKENA) begin
         w <= '0;
      end else if (w < W_MAX) begin
         w <= w + 1'b1;
      end
   end

   // Fill counter: how many real samples the delay line holds, saturating at two.
   always_ff @(posedge CLK21M or negedge RESET_N) begin
      if (!RESET_N) begin
         fill <= '0;
      end else if (pix.CLKENA && (fill != 2'd2)) begin
         fill <= fill + 2'd1;
      end
   end

   // Valid flag travels through two registers to line up with the datapath.
   always_ff @(posedge CLK21M or negedge RESET_N) begin
      if (!RESET_N) begin
         valid_s1 <= 1'b0;
         ovalid_q <= 1'b0;
      end else begin
         valid_s1 <= (fill == 2'd2);
         ovalid_q <= valid_s1;
      end
   end

   assign weff       = pix.ENABLE ? w : '0;
   assign pix.OVALID = ovalid_q;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      interpo_chan #(
         .WIDTH (WIDTH),
         .RATIO (RATIO)
      ) u_chan (
         .CLK21M  (CLK21M),
         .RESET_N (RESET_N),
         .clkena  (pix.CLKENA),
         .weff    (weff),
         .idata   (pix.IDATA[c*WIDTH +: WIDTH]),
         .odata   (chan_out[c])
      );
   end

   // Pack the per-channel results back into the output bus layout.
   always_comb begin
      odata_bus = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         odata_bus[c*WIDTH +: WIDTH] = chan_out[c];
      end
   end

   assign pix.ODATA = odata_bus;

endmodule

// File: tb/tb_interpo_multi.sv
// Self-checking bench for interpo_multi: directed scenarios plus a random
// stream, compared cycle by cycle with an arithmetic reference model.
// Honours INTERPO_MULTI_ROUND_EN in the reference model.
module tb_interpo_multi;

   localparam int WIDTH    = 8;
   localparam int CHANNELS = 3;
   localparam int RATIO    = 6;
   localparam int MAXV     = (1 << WIDTH) - 1;
   localparam int BUS_W    = CHANNELS * WIDTH;

   logic CLK21M;
   logic RESET_N;

   interpo_multi_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

   interpo_multi #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS),
      .RATIO    (RATIO)
   ) dut (
      .CLK21M  (CLK21M),
      .RESET_N (RESET_N),
      .pix     (bus)
   );

   initial CLK21M = 1'b0;
   always #5 CLK21M = ~CLK21M;

   int checks = 0;
   int errors = 0;

   // Reference model: sample history, time since last strobe, sample count,
   // and the values expected to emerge after the two-cycle latency.
   int hist_old [CHANNELS];
   int hist_new [CHANNELS];
   int since_strobe;
   int n_samples;
   int lat1 [CHANNELS];
   int lat2 [CHANNELS];
   int vld1;
   int vld2;

   function automatic int floorDiv(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   function automatic int expectInterp(input int older, input int newer, input int weight);
      int p;
      int q;
      int s;
      p = (newer - older) * weight;
`ifdef INTERPO_MULTI_ROUND_EN
      q = floorDiv(2 * p + RATIO, 2 * RATIO);
`else
      q = floorDiv(p, RATIO);
`endif
      s = older + q;
      if (s < 0) s = 0;
      if (s > MAXV) s = MAXV;
      return s;
   endfunction

   function automatic logic [BUS_W-1:0] pack3(input int c2, input int c1, input int c0);
      return {c2[WIDTH-1:0], c1[WIDTH-1:0], c0[WIDTH-1:0]};
   endfunction

   task automatic modelReset();
      for (int c = 0; c < CHANNELS; c++) begin
         hist_old[c] = 0;
         hist_new[c] = 0;
         lat1[c]     = 0;
         lat2[c]     = 0;
      end
      since_strobe = 0;
      n_samples    = 0;
      vld1         = 0;
      vld2         = 0;
   endtask

   task automatic modelEdge(input logic strobe, input logic en, input logic [BUS_W-1:0] data);
      for (int c = 0; c < CHANNELS; c++) begin
         lat2[c] = lat1[c];
         lat1[c] = expectInterp(hist_old[c], hist_new[c], en ? since_strobe : 0);
      end
      vld2 = vld1;
      vld1 = (n_samples >= 2) ? 1 : 0;
      if (strobe) begin
         for (int c = 0; c < CHANNELS; c++) begin
            hist_old[c] = hist_new[c];
            hist_new[c] = int'(data[c*WIDTH +: WIDTH]);
         end
         if (n_samples < 2) n_samples++;
         since_strobe = 0;
      end else if (since_strobe < RATIO - 1) begin
         since_strobe++;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, want %0d", tag, actual, expected);
      end
   endtask

   task automatic compareAll();
      for (int c = 0; c < CHANNELS; c++) begin
         checkOutput($sformatf("odata_ch%0d", c), 32'(bus.ODATA[c*WIDTH +: WIDTH]), 32'(lat2[c]));
      end
      checkOutput("ovalid", 32'(bus.OVALID), 32'(vld2));
   endtask

   // Called at a falling edge: drive inputs, let one rising edge pass, then compare.
   task automatic applyStimulus(input logic strobe, input logic en, input logic [BUS_W-1:0] data);
      bus.CLKENA = strobe;
      bus.ENABLE = en;
      bus.IDATA  = data;
      @(posedge CLK21M);
      modelEdge(strobe, en, data);
      @(negedge CLK21M);
      compareAll();
   endtask

   task automatic idleCycles(input logic en, input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, en, bus.IDATA);
   endtask

   int          neg_ramp [6];
   logic [31:0] exp_indep;
   int          exp_bypass_w3;
   int          gap;
   logic        rnd_en;

   initial begin
`ifdef INTERPO_MULTI_ROUND_EN
      neg_ramp      = '{200, 183, 167, 150, 133, 117};
      exp_indep     = 32'h0080_8080;
      exp_bypass_w3 = 129;
`else
      neg_ramp      = '{200, 183, 166, 150, 133, 116};
      exp_indep     = 32'h0080_7F7F;
      exp_bypass_w3 = 128;
`endif

      RESET_N    = 1'b0;
      bus.CLKENA = 1'b0;
      bus.ENABLE = 1'b1;
      bus.IDATA  = '0;
      modelReset();
      repeat (3) @(negedge CLK21M);
      checkOutput("reset_odata", 32'(bus.ODATA), 32'd0);
      checkOutput("reset_ovalid", 32'(bus.OVALID), 32'd0);
      RESET_N = 1'b1;

      // Ramp 0 -> 60 on ch0, then a long gap so the weight parks at RATIO-1.
      applyStimulus(1'b1, 1'b1, pack3(0, 0, 0));
      idleCycles(1'b1, 5);
      applyStimulus(1'b1, 1'b1, pack3(0, 0, 60));
      for (int i = 1; i <= 12; i++) begin
         applyStimulus(1'b0, 1'b1, pack3(0, 0, 60));
         if (i == 1) checkOutput("valid_not_yet", 32'(bus.OVALID), 32'd0);
         if (i >= 2) begin
            checkOutput("ramp_ch0", 32'(bus.ODATA[WIDTH-1:0]), 32'(((i - 2) > 5 ? 5 : (i - 2)) * 10));
            checkOutput("ramp_valid", 32'(bus.OVALID), 32'd1);
         end
      end

      // Falling ramp 200 -> 100 exercises the negative-product division.
      applyStimulus(1'b1, 1'b1, pack3(200, 200, 200));
      idleCycles(1'b1, 5);
      applyStimulus(1'b1, 1'b1, pack3(100, 100, 100));
      for (int i = 1; i <= 7; i++) begin
         applyStimulus(1'b0, 1'b1, pack3(100, 100, 100));
         if (i >= 2) checkOutput("neg_ramp_ch0", 32'(bus.ODATA[WIDTH-1:0]), 32'(neg_ramp[i - 2]));
      end

      // Bypass holds D1, then ENABLE rises mid-interval.
      applyStimulus(1'b1, 1'b0, pack3(17, 17, 17));
      idleCycles(1'b0, 5);
      applyStimulus(1'b1, 1'b0, pack3(240, 240, 240));
      for (int i = 1; i <= 7; i++) begin
         applyStimulus(1'b0, (i >= 4), pack3(240, 240, 240));
         if (i >= 2 && i <= 4) checkOutput("bypass_ch0", 32'(bus.ODATA[WIDTH-1:0]), 32'd17);
         if (i == 5) checkOutput("enable_rise_ch0", 32'(bus.ODATA[WIDTH-1:0]), 32'(exp_bypass_w3));
      end

      // Channel independence: rising, falling and flat channels together.
      applyStimulus(1'b1, 1'b1, pack3(128, 255, 0));
      idleCycles(1'b1, 5);
      applyStimulus(1'b1, 1'b1, pack3(128, 0, 255));
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b0, 1'b1, pack3(128, 0, 255));
      end
      checkOutput("indep_w3", 32'(bus.ODATA), exp_indep);

      // Consecutive strobes: output follows D1 directly.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b1, pack3(i * 40, 255 - i * 30, i * 7 + 3));
      end
      idleCycles(1'b1, 3);

      // Asynchronous reset between clock edges.
      #2;
      RESET_N = 1'b0;
      #1;
      checkOutput("async_rst_odata", 32'(bus.ODATA), 32'd0);
      checkOutput("async_rst_ovalid", 32'(bus.OVALID), 32'd0);
      modelReset();
      @(negedge CLK21M);
      @(negedge CLK21M);
      RESET_N = 1'b1;
      applyStimulus(1'b1, 1'b1, pack3(90, 30, 200));
      idleCycles(1'b1, 6);
      checkOutput("one_strobe_no_valid", 32'(bus.OVALID), 32'd0);
      applyStimulus(1'b1, 1'b1, pack3(10, 250, 40));
      idleCycles(1'b1, 6);
      checkOutput("two_strobes_valid", 32'(bus.OVALID), 32'd1);

      // Random stream: random gaps (including back-to-back strobes and late strobes) and mode flips.
      rnd_en = 1'b1;
      for (int k = 0; k < 60; k++) begin
         gap = $urandom_range(0, 11);
         if ($urandom_range(0, 5) == 0) rnd_en = ~rnd_en;
         applyStimulus(1'b1, rnd_en, BUS_W'($urandom));
         for (int j = 0; j < gap; j++) begin
            if ($urandom_range(0, 9) == 0) rnd_en = ~rnd_en;
            applyStimulus(1'b0, rnd_en, bus.IDATA);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/interpo_multi.md
Name: interpo_multi

Overview:
Multi-channel linear interpolation filter that upsamples a low-rate pixel/sample stream to the CLK21M rate. It replaces the single-channel, fixed 6x interpolator. It generalises channel count, sample width and upsampling ratio, and adds saturating weights, a bypass mode, an output-valid flag and a 2-stage pipelined datapath. It sits between the video DAC-side pixel pipeline and the output encoder; typically it carries R, G and B together.

Parameters:
WIDTH, 8, bits per channel sample (unsigned).
CHANNELS, 3, number of independent channels packed in IDATA/ODATA.
RATIO, 6, nominal CLK21M cycles per input sample; the interpolation denominator. Legal range 2..16.

Ports:
CLK21M  in  1  system clock; all logic is on its rising edge.
RESET_N  in  1  asynchronous, active-low reset.
CLKENA  in  1  input sample strobe, one cycle wide; IDATA is valid when it is high.
ENABLE  in  1  1 = interpolate; 0 = bypass (sample-and-hold of D1).
IDATA  in  CHANNELS*WIDTH  input samples; channel c occupies bits [c*WIDTH +: WIDTH].
ODATA  out  CHANNELS*WIDTH  interpolated output, packed the same way as IDATA.
OVALID  out  1  high once the delay line holds two real samples.

Behaviour:
- Reset (RESET_N=0, asynchronous): D1, D2, W, the pipeline registers, ODATA and OVALID all go to 0. The fill counter FILL also goes to 0.
- Delay line, per channel, on CLKENA=1: D2<=IDATA and D1<=D2. FILL increments, saturating at 2.
- Weight counter W, shared by all channels, width clog2(RATIO):
  - CLKENA=1 -> W<=0.
  - Otherwise, if W<RATIO-1 -> W<=W+1.
  - Otherwise W holds at RATIO-1. It never wraps; this covers a late strobe.
- Stage 1 registers, per channel:
  - DIFF = D2-D1, signed, WIDTH+1 bits.
  - P = DIFF*Weff, signed.
  - D1 copy.
  - Weff = W when ENABLE=1, otherwise 0.
- Stage 2 registers ODATA, per channel:
  - Q = floor(P/RATIO), rounding toward minus infinity.
  - S = D1 + Q.
  - ODATA = clamp(S, 0, 2^WIDTH-1). Because W<RATIO, S always lies between D1 and D2; the clamp is defensive and must still be present.
- The division must be exact for every legal P. A constant reciprocal-multiply is allowed only if it is bit-exact over the full range.
- Latency: ODATA reflects the D/W values registered 2 cycles earlier. After a CLKENA edge, ODATA equals the new D1 exactly 2 cycles later.
- OVALID <= (FILL==2), delayed 2 cycles to match the pipeline. It stays 0 until the second CLKENA after reset has propagated.
- CLKENA on consecutive cycles: each strobe shifts the delay line and clears W, so ODATA tracks D1 with no interpolation steps.
- ENABLE toggling takes effect on samples entering stage 1 in the same cycle; there is no glitch or extra latency.
- Reset asserted mid-stream clears everything immediately. Interpolation restarts from a zero history.

Optional Feature:
Macro INTERPO_MULTI_ROUND_EN.
- Defined: Q = floor((2*P + RATIO) / (2*RATIO)), i.e. round-half-up to nearest.
- Undefined: Q = floor(P/RATIO).
- Latency, clamp and all other behaviour are identical in both cases.

Decomposition:
- Package interpo_pkg:
  - clog2 function.
  - Derived localparams W_W = clog2(RATIO), DIFF_W = WIDTH+1, PROD_W = DIFF_W+W_W+1.
  - Saturate/clamp function.
- Sub-module interpo_chan:
  - Holds one channel's D1/D2, stage-1 and stage-2 registers, the divider and the clamp.
  - Instantiated CHANNELS times via generate.
- The W counter, FILL and OVALID logic live in the top level.

Test Plan:
- Reset then hold (WIDTH=8, RATIO=6, ENABLE=1): send IDATA ch0 = 0, then 60, with CLKENA every 6 cycles -> OVALID=0 until 2 cycles after the 2nd strobe. ODATA ch0 then steps 0,10,20,30,40,50.
- Negative ramp: D1=200, D2=100, W=0..5 -> ODATA = 200,183,166,150,133,116 (floor). With INTERPO_MULTI_ROUND_EN -> 200,183,167,150,133,117.
- Late strobe: CLKENA gap of 10 cycles with D1=0, D2=60 -> W saturates at 5 and ODATA holds at 50 until the next strobe.
- Bypass: ENABLE=0, D1=17, D2=240 -> ODATA=17 for all W. Raising ENABLE mid-interval gives the interpolated value 2 cycles later.
- Channel independence, CHANNELS=3: ch0 0->255, ch1 255->0, ch2 constant 128 -> at W=3, ODATA = {128, 127, 127} for ch2, ch1, ch0 (ch1 = 255+floor(-255*3/6) = 127). No cross-channel bits.
- Async reset mid-interval: pull RESET_N low between edges -> ODATA=0 and OVALID=0 immediately, without waiting for a clock edge. After release, two strobes are needed before OVALID=1 again.
